match_sequencer: RTL and testbench
==================================

// Module: match_sequencer
// PURPOSE
//  Match-level controller sitting above the per-round baccarat FSM. Sequences rounds
//  by driving that FSM's synchronous reset, watches its player/dealer win lights to detect
//  round completion, tallies player/dealer/tie round counts, and declares a best-of-N
//  match winner. A deal watchdog flags a round FSM that never finishes.
// PARAMETERS
//  ROUNDS_TO_WIN  3   round wins that end the match immediately
//  MAX_ROUNDS     9   rounds played (ties included) after which the match ends
//  CNT_W          4   width of all round counters; MAX_ROUNDS < 2**CNT_W
//  DEAL_TIMEOUT   15  slow_clock cycles allowed in DEAL before fault
// PORTS
//  slow_clock        in   1      clock
//  resetb            in   1      synchronous, active-low reset
//  next_n            in   1      active-low pushbutton: start / next round / new match
//  player_win_light  in   1      from round FSM; high only in its game-over state
//  dealer_win_light  in   1      from round FSM; both high = tied round
//  round_resetb      out  1      active-low sync reset to round FSM
//  round_active      out  1      high while a round is being dealt (DEAL)
//  player_rounds     out  CNT_W  rounds won by player
//  dealer_rounds     out  CNT_W  rounds won by dealer
//  tie_rounds        out  CNT_W  tied rounds
//  round_count       out  CNT_W  rounds completed this match
//  match_over        out  1      match decided
//  match_player_win  out  1      player won match (both win outputs high = drawn match)
//  match_dealer_win  out  1      dealer won match
//  fault             out  1      sticky watchdog error
// BEHAVIOUR
//  - Reset (resetb low at posedge): state IDLE, all counters 0, match_* 0, fault 0,
//    watchdog 0, synchroniser flops 1 (button released). round_resetb 0 in IDLE.
//  - next_n: 2-flop synchroniser then falling-edge detect -> press = 1-cycle pulse. Holding
//    button yields exactly one press. Presses outside IDLE/WAIT/DONE are discarded.
//  - Outputs are Moore decodes of state/registers; no input-to-output comb path.
//  - States:
//    IDLE : round_resetb=0. press -> RST.
//    RST  : round_resetb=0 for exactly 1 cycle (round FSM lands in its start state) -> DEAL.
//    DEAL : round_resetb=1, round_active=1, watchdog++ each cycle. Any light high -> TALLY.
//           watchdog reaching DEAL_TIMEOUT with no light -> FAULT.
//    TALLY: 1 cycle; both lights (latched at DEAL exit) -> tie_rounds++; only player ->
//           player_rounds++; only dealer -> dealer_rounds++; round_count++ always.
//           Then: next player/dealer count == ROUNDS_TO_WIN or next round_count == MAX_ROUNDS
//           -> DONE, else -> WAIT. Decision uses post-increment values (same-cycle compare).
//    WAIT : round_resetb=1 (lights remain visible). press -> RST.
//    DONE : match_over=1; player_rounds>dealer_rounds -> match_player_win; < -> dealer;
//           equal -> both high. press -> clear all counters and match_*, go RST.
//    FAULT: fault=1, round_resetb=0, round_active=0; exits only via resetb.
//  - Watchdog clears on entry to DEAL. Counters saturate at 2**CNT_W-1 (unreachable
//    when parameters legal). Reset mid-round: next cycle IDLE, round FSM held in reset.
// STRUCTURE
//  - baccarat_pkg: match_state_t enum (IDLE,RST,DEAL,TALLY,WAIT,DONE,FAULT), default
//    ROUNDS_TO_WIN/MAX_ROUNDS/DEAL_TIMEOUT constants.
//  - Sub-module button_pulse: 2-flop sync + falling-edge detect, reset to released.
//  - match_sequencer: FSM, light latch, four counters, watchdog, match decision.
// TESTING
//  1. resetb low 2 cycles -> round_resetb=0, all counts 0, match_over=0, fault=0.
//  2. press; model round FSM raises player light 6 cycles after RST -> round_resetb low
//     exactly 1 cycle, round_active 6 cycles, player_rounds=1, round_count=1, state WAIT.
//  3. Player wins 3 straight rounds -> after 3rd TALLY match_over=1, match_player_win=1,
//     match_dealer_win=0; round_count=3; press -> counters cleared, RST issued.
//  4. 9 rounds: 4 player, 4 dealer, 1 tie... -> order so no side hits 3 early impossible;
//     use ROUNDS_TO_WIN=5: 4P/4D/1T -> DONE at round 9, both match win outputs high.
//  5. Round FSM never lights in DEAL -> fault=1 after 15 cycles, round_resetb=0; presses
//     ignored; resetb clears fault.
//  6. Hold next_n low 20 cycles during WAIT -> exactly one RST; press during DEAL ignored;
//     resetb low mid-DEAL -> IDLE next cycle, counts 0.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared types and default constants for the baccarat match controller.
package baccarat_pkg;

   // Match-level sequencing states
   typedef enum logic [2:0] {
      IDLE,
      RST,
      DEAL,
      TALLY,
      WAIT,
      DONE,
      FAULT
   } match_state_t;

   localparam int ROUNDS_TO_WIN_DEF = 3;
   localparam int MAX_ROUNDS_DEF    = 9;
   localparam int DEAL_TIMEOUT_DEF  = 15;
   localparam int CNT_W_DEF         = 4;

endpackage

// File: rtl/button_pulse.sv
// Active-low pushbutton conditioner: two-flop synchroniser followed by a
// falling-edge detector. A held button produces exactly one press pulse.
module button_pulse (
   input  logic slow_clock,
   input  logic resetb,
   input  logic btn_n_i,
   output logic press_o
);

   logic sync1_q;
   logic sync2_q;
   logic last_q;

   // Synchronise the button and keep one delayed copy for edge detection
   always_ff @(posedge slow_clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!resetb) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         last_q  <= 1'b1;
      end else begin
         sync1_q <= btn_n_i;
         sync2_q <= sync1_q;
         last_q  <= sync2_q;
      end
   end

   assign press_o = last_q & ~sync2_q;

endmodule

// File: rtl/match_sequencer.sv
// Match-level controller: resets the round FSM for each round, waits for its
// win lights, tallies round results and decides a best-of-N match. A deal
// watchdog traps a round FSM that never finishes.
module match_sequencer
   import baccarat_pkg::*;
#(
   parameter int ROUNDS_TO_WIN = ROUNDS_TO_WIN_DEF,
   parameter int MAX_ROUNDS    = MAX_ROUNDS_DEF,
   parameter int CNT_W         = CNT_W_DEF,
   parameter int DEAL_TIMEOUT  = DEAL_TIMEOUT_DEF
) (
   input  logic             slow_clock,
   input  logic             resetb,
   input  logic             next_n,
   input  logic             player_win_light,
   input  logic             dealer_win_light,
   output logic             round_resetb,
   output logic             round_active,
   output logic [CNT_W-1:0] player_rounds,
   output logic [CNT_W-1:0] dealer_rounds,
   output logic [CNT_W-1:0] tie_rounds,
   output logic [CNT_W-1:0] round_count,
   output logic             match_over,
   output logic             match_player_win,
   output logic             match_dealer_win,
   output logic             fault
);

   localparam int WD_W = $clog2(DEAL_TIMEOUT + 1);

   match_state_t     state_q, state_d;
   logic [CNT_W-1:0] player_q, player_d;
   logic [CNT_W-1:0] dealer_q, dealer_d;
   logic [CNT_W-1:0] tie_q, tie_d;
   logic [CNT_W-1:0] rounds_q, rounds_d;
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic             lp_q, lp_d;
   logic             ld_q, ld_d;
   logic             round_resetb_q, round_active_q, match_over_q;
   logic             match_player_q, match_dealer_q, fault_q;
   logic             press;

   button_pulse u_button (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .btn_n_i    (next_n),
      .press_o    (press)
   );

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // Next-state, counter, watchdog and light-latch logic
   always_comb begin
      // NOTE: every comb output takes a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      player_d = player_q;
      dealer_d = dealer_q;
      tie_d    = tie_q;
      rounds_d = rounds_q;
      wdog_d   = wdog_q;
      lp_d     = lp_q;
      ld_d     = ld_q;
      unique case (state_q)
         IDLE: if (press) state_d = RST;
         RST: begin
            state_d = DEAL;
            wdog_d  = '0;
         end
         DEAL: begin
            if (player_win_light || dealer_win_light) begin
               state_d = TALLY;
               lp_d    = player_win_light;
               ld_d    = dealer_win_light;
            end else if (wdog_q == WD_W'(DEAL_TIMEOUT - 1)) begin
               state_d = FAULT;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         TALLY: begin
            if (lp_q && ld_q)  tie_d    = sat_inc(tie_q);
            else if (lp_q)     player_d = sat_inc(player_q);
            else if (ld_q)     dealer_d = sat_inc(dealer_q);
            rounds_d = sat_inc(rounds_q);
            // Decide on the post-increment counts so the match ends this cycle
            if (player_d == CNT_W'(ROUNDS_TO_WIN) || dealer_d == CNT_W'(ROUNDS_TO_WIN) ||
                rounds_d == CNT_W'(MAX_ROUNDS))
               state_d = DONE;
            else
               state_d = WAIT;
         end
         WAIT: if (press) state_d = RST;
         DONE: begin
            if (press) begin
               state_d  = RST;
               player_d = '0;
               dealer_d = '0;
               tie_d    = '0;
               rounds_d = '0;
            end
         end
         FAULT: state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // State register plus registered Moore outputs decoded from the next state
   always_ff @(posedge slow_clock) begin
      if (!resetb) begin
         state_q        <= IDLE;
         player_q       <= '0;
         dealer_q       <= '0;
         tie_q          <= '0;
         rounds_q       <= '0;
         wdog_q         <= '0;
         lp_q           <= 1'b0;
         ld_q           <= 1'b0;
         round_resetb_q <= 1'b0;
         round_active_q <= 1'b0;
         match_over_q   <= 1'b0;
         match_player_q <= 1'b0;
         match_dealer_q <= 1'b0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         player_q       <= player_d;
         dealer_q       <= dealer_d;
         tie_q          <= tie_d;
         rounds_q       <= rounds_d;
         wdog_q         <= wdog_d;
         lp_q           <= lp_d;
         ld_q           <= ld_d;
         // Round FSM runs (and keeps its lights visible) from DEAL through DONE
         round_resetb_q <= (state_d == DEAL) || (state_d == TALLY) ||
                           (state_d == WAIT) || (state_d == DONE);
         round_active_q <= (state_d == DEAL);
         match_over_q   <= (state_d == DONE);
         match_player_q <= (state_d == DONE) && (player_d >= dealer_d);
         match_dealer_q <= (state_d == DONE) && (dealer_d >= player_d);
         fault_q        <= (state_d == FAULT);
      end
   end

   assign round_resetb     = round_resetb_q;
   assign round_active     = round_active_q;
   assign player_rounds    = player_q;
   assign dealer_rounds    = dealer_q;
   assign tie_rounds       = tie_q;
   assign round_count      = rounds_q;
   assign match_over       = match_over_q;
   assign match_player_win = match_player_q;
   assign match_dealer_win = match_dealer_q;
   assign fault            = fault_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Bench for match_sequencer: a behavioural round FSM raises its win lights a
// programmable number of cycles after release from reset; expected tallies are
// queued when a round is launched and compared when round_count advances.
module tb_match_sequencer;

   logic       slow_clock = 1'b0;
   logic       resetb     = 1'b0;
   logic       next_n     = 1'b1;
   logic       player_win_light;
   logic       dealer_win_light;
   logic       round_resetb;
   logic       round_active;
   logic [3:0] player_rounds;
   logic [3:0] dealer_rounds;
   logic [3:0] tie_rounds;
   logic [3:0] round_count;
   logic       match_over;
   logic       match_player_win;
   logic       match_dealer_win;
   logic       fault;

   int checks = 0;
   int errors = 0;

   match_sequencer dut (
      .slow_clock       (slow_clock),
      .resetb           (resetb),
      .next_n           (next_n),
      .player_win_light (player_win_light),
      .dealer_win_light (dealer_win_light),
      .round_resetb     (round_resetb),
      .round_active     (round_active),
      .player_rounds    (player_rounds),
      .dealer_rounds    (dealer_rounds),
      .tie_rounds       (tie_rounds),
      .round_count      (round_count),
      .match_over       (match_over),
      .match_player_win (match_player_win),
      .match_dealer_win (match_dealer_win),
      .fault            (fault)
   );

   always #5 slow_clock = ~slow_clock;

   // Behavioural round FSM: cycle counter held at 0 while in reset
   int   model_delay = -1;
   logic model_p     = 1'b0;
   logic model_d     = 1'b0;
   int   mcnt        = 0;

   always @(posedge slow_clock) begin
      if (!round_resetb) mcnt <= 0;
      else if (mcnt < 255) mcnt <= mcnt + 1;
   end

   always_comb begin
      player_win_light = (model_delay >= 0) && (mcnt >= model_delay) && model_p;
      dealer_win_light = (model_delay >= 0) && (mcnt >= model_delay) && model_d;
   end

   // Scoreboard of expected counter / match outputs after each tally
   typedef struct {
      logic [3:0] p, d, t, n;
      logic       over, mp, md;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   sb_entry_t mon_e;
   logic [3:0] prev_rc = '0;
   int ep = 0, ed = 0, et = 0, en = 0;
   bit edone = 0;

   always @(negedge slow_clock) begin
      if (resetb && round_count !== prev_rc && round_count != 4'd0) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_tally round_count=%0d with no queued expectation", round_count);
         end else begin
            mon_e = sb_q.pop_front();
            if ({player_rounds, dealer_rounds, tie_rounds, round_count,
                 match_over, match_player_win, match_dealer_win} !==
                {mon_e.p, mon_e.d, mon_e.t, mon_e.n, mon_e.over, mon_e.mp, mon_e.md}) begin
               errors++;
               $display("FAIL sb_tally got p=%0d d=%0d t=%0d n=%0d over=%b mp=%b md=%b exp p=%0d d=%0d t=%0d n=%0d over=%b mp=%b md=%b",
                        player_rounds, dealer_rounds, tie_rounds, round_count,
                        match_over, match_player_win, match_dealer_win,
                        mon_e.p, mon_e.d, mon_e.t, mon_e.n, mon_e.over, mon_e.mp, mon_e.md);
            end
         end
      end
      prev_rc = round_count;
   end

   task automatic apply_reset();
      @(negedge slow_clock);
      resetb = 1'b0;
      next_n = 1'b1;
      model_delay = -1;
      repeat (2) @(negedge slow_clock);
      resetb = 1'b1;
      sb_q.delete();
      ep = 0; ed = 0; et = 0; en = 0; edone = 0;
   endtask

   // Launch one round: press for 'hold' cycles, optional second press
   // 'extra_at' cycles into DEAL, then observe for a fixed window.
   task automatic run_round(input logic wp, input logic wd, input int delay, input int hold,
                            input int extra_at, input bit chk_rst, input string tag);
      sb_entry_t e;
      int   rst_low = 0;
      int   active  = 0;
      int   entries = 0;
      int   pre;
      logic prev_act = 1'b0;
      if (edone) begin
         ep = 0; ed = 0; et = 0; en = 0; edone = 0;
      end
      pre = en;
      if (wp && wd) et++;
      else if (wp)  ep++;
      else          ed++;
      en++;
      edone = (ep == 3) || (ed == 3) || (en == 9);
      e.p = 4'(ep); e.d = 4'(ed); e.t = 4'(et); e.n = 4'(en);
      e.over = edone;
      e.mp   = edone && (ep >= ed);
      e.md   = edone && (ed >= ep);
      sb_q.push_back(e);
      model_p = wp; model_d = wd; model_delay = delay;
      next_n = 1'b0;
      for (int c = 0; c < hold + delay + 15; c++) begin
         @(negedge slow_clock);
         if (c == hold - 1) next_n = 1'b1;
         if (round_active && !prev_act) begin
            entries++;
            if (entries == 1) begin
               checks++;
               if (round_count !== 4'(pre) || match_over !== 1'b0) begin
                  errors++;
                  $display("FAIL %s_deal_entry round_count=%0d match_over=%b exp %0d/0", tag, round_count, match_over, pre);
               end
            end
         end
         if (entries == 0 && !round_resetb) rst_low++;
         if (round_active) begin
            active++;
            if (extra_at > 0 && active == extra_at)     next_n = 1'b0;
            if (extra_at > 0 && active == extra_at + 3) next_n = 1'b1;
         end
         prev_act = round_active;
      end
      next_n = 1'b1;
      checks++;
      if (entries != 1) begin
         errors++;
         $display("FAIL %s_deal_entries got %0d exp 1", tag, entries);
      end
      checks++;
      if (active != delay + 1) begin
         errors++;
         $display("FAIL %s_active_cycles got %0d exp %0d", tag, active, delay + 1);
      end
      if (chk_rst) begin
         checks++;
         if (rst_low != 1) begin
            errors++;
            $display("FAIL %s_round_reset_len got %0d exp 1", tag, rst_low);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({round_resetb, round_active, player_rounds, dealer_rounds, tie_rounds, round_count,
           match_over, match_player_win, match_dealer_win, fault} !== 22'd0) begin
         errors++;
         $display("FAIL reset_state rr=%b ra=%b p=%0d d=%0d t=%0d n=%0d over=%b f=%b exp all 0",
                  round_resetb, round_active, player_rounds, dealer_rounds, tie_rounds,
                  round_count, match_over, fault);
      end
   endtask

   task automatic test_first_round();
      run_round(1'b1, 1'b0, 5, 2, 0, 1'b0, "first");
      checks++;
      if (round_resetb !== 1'b1 || round_active !== 1'b0 || match_over !== 1'b0 ||
          player_rounds !== 4'd1 || round_count !== 4'd1) begin
         errors++;
         $display("FAIL first_wait rr=%b ra=%b over=%b p=%0d n=%0d exp 1 0 0 1 1",
                  round_resetb, round_active, match_over, player_rounds, round_count);
      end
   endtask

   task automatic test_player_sweep();
      run_round(1'b1, 1'b0, 2, 2, 0, 1'b1, "sweep2");
      run_round(1'b1, 1'b0, 0, 2, 0, 1'b1, "sweep3");
      checks++;
      if (match_over !== 1'b1 || match_player_win !== 1'b1 || match_dealer_win !== 1'b0 ||
          round_count !== 4'd3) begin
         errors++;
         $display("FAIL sweep_done over=%b mp=%b md=%b n=%0d exp 1 1 0 3",
                  match_over, match_player_win, match_dealer_win, round_count);
      end
      // New match from DONE: counters must be cleared at DEAL entry
      run_round(1'b0, 1'b1, 3, 2, 0, 1'b1, "newmatch");
   endtask

   task automatic test_drawn_match();
      logic [1:0] seq [9] = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11};
      apply_reset();
      for (int i = 0; i < 9; i++)
         run_round(seq[i][1], seq[i][0], i % 4, 2, 0, (i != 0), "draw");
      checks++;
      if (match_over !== 1'b1 || match_player_win !== 1'b1 || match_dealer_win !== 1'b1 ||
          round_count !== 4'd9 || tie_rounds !== 4'd5) begin
         errors++;
         $display("FAIL draw_done over=%b mp=%b md=%b n=%0d t=%0d exp 1 1 1 9 5",
                  match_over, match_player_win, match_dealer_win, round_count, tie_rounds);
      end
   endtask

   task automatic test_watchdog();
      int active = 0;
      apply_reset();
      model_delay = -1;
      next_n = 1'b0;
      for (int c = 0; c < 40 && fault !== 1'b1; c++) begin
         @(negedge slow_clock);
         if (c == 1) next_n = 1'b1;
         if (round_active) active++;
      end
      checks++;
      if (fault !== 1'b1 || active != 15 || round_resetb !== 1'b0 || round_active !== 1'b0) begin
         errors++;
         $display("FAIL wdog_trip fault=%b deal_cycles=%0d rr=%b ra=%b exp 1 15 0 0",
                  fault, active, round_resetb, round_active);
      end
      active = 0;
      next_n = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge slow_clock);
         if (c == 3) next_n = 1'b1;
         if (round_active || round_resetb) active++;
      end
      checks++;
      if (fault !== 1'b1 || active != 0) begin
         errors++;
         $display("FAIL wdog_sticky fault=%b restart_cycles=%0d exp 1 0", fault, active);
      end
      apply_reset();
      checks++;
      if (fault !== 1'b0 || round_resetb !== 1'b0) begin
         errors++;
         $display("FAIL wdog_clear fault=%b rr=%b exp 0 0", fault, round_resetb);
      end
   endtask

   task automatic test_button_and_midreset();
      apply_reset();
      run_round(1'b1, 1'b0, 5, 2, 0, 1'b0, "hold_pre");
      run_round(1'b0, 1'b1, 5, 20, 0, 1'b1, "hold20");
      run_round(1'b1, 1'b0, 10, 2, 2, 1'b1, "deal_press");
      // Start another round and pull reset while it is being dealt
      model_delay = 30;
      next_n = 1'b0;
      for (int c = 0; c < 12 && round_active !== 1'b1; c++) @(negedge slow_clock);
      next_n = 1'b1;
      repeat (2) @(negedge slow_clock);
      checks++;
      if (round_active !== 1'b1 || round_count !== 4'd3) begin
         errors++;
         $display("FAIL midreset_setup ra=%b n=%0d exp 1 3", round_active, round_count);
      end
      resetb = 1'b0;
      @(negedge slow_clock);
      resetb = 1'b1;
      sb_q.delete();
      ep = 0; ed = 0; et = 0; en = 0; edone = 0;
      checks++;
      if (round_active !== 1'b0 || round_resetb !== 1'b0 || round_count !== 4'd0 ||
          player_rounds !== 4'd0 || dealer_rounds !== 4'd0) begin
         errors++;
         $display("FAIL midreset_idle ra=%b rr=%b n=%0d p=%0d d=%0d exp all 0",
                  round_active, round_resetb, round_count, player_rounds, dealer_rounds);
      end
      repeat (5) @(negedge slow_clock);
      checks++;
      if (round_active !== 1'b0 || round_resetb !== 1'b0) begin
         errors++;
         $display("FAIL midreset_stay_idle ra=%b rr=%b exp 0 0", round_active, round_resetb);
      end
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_player_sweep();
      test_drawn_match();
      test_watchdog();
      test_button_and_midreset();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending exp 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
